// File: rtl/mdu_e.sv
// Multiply/divide unit for the execute stage: multi-cycle mult/div with a
// pending result, architectural HI/LO, and single-cycle mthi/mtlo/mfhi/mflo.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | no operation in flight; accepts start and mthi/mtlo
// ST_BUSY | counting down; pending result lands in HI/LO at count 1
module mdu_e #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDUop,
  input  logic        start,
  input  logic [31:0] inA,
  input  logic [31:0] inB,
  input  logic        req,
  output logic        busy,
  output logic [31:0] MDUout,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = ($clog2(MAX_CYC + 1) < 4) ? 4 : $clog2(MAX_CYC + 1);

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      pend_hi;
  logic [31:0]      pend_lo;
  logic             pend_wr;

  logic             is_mdop;
  logic             is_mult;
  logic             is_div_s;
  logic             accept;

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic               a_neg;
  logic               b_neg;
  logic [31:0]        a_mag;
  logic [31:0]        b_mag;
  logic               div_zero;
  logic [31:0]        divisor;
  logic [31:0]        q_mag;
  logic [31:0]        r_mag;
  logic [31:0]        q_res;
  logic [31:0]        r_res;

  logic [31:0]        res_hi;
  logic [31:0]        res_lo;
  logic               res_wr;

  assign busy     = (state == ST_BUSY);
  assign is_mdop  = (MDUop >= OP_MULT) && (MDUop <= OP_DIVU);
  assign is_mult  = (MDUop == OP_MULT) || (MDUop == OP_MULTU);
  assign is_div_s = (MDUop == OP_DIV);
  assign accept   = start && is_mdop && !busy && !req;

  assign prod_s = $signed({{32{inA[31]}}, inA}) * $signed({{32{inB[31]}}, inB});
  assign prod_u = {32'd0, inA} * {32'd0, inB};

  // Signed division runs on magnitudes so 0x80000000 / -1 needs no special case.
  assign a_neg    = is_div_s && inA[31];
  assign b_neg    = is_div_s && inB[31];
  assign a_mag    = a_neg ? (32'd0 - inA) : inA;
  assign b_mag    = b_neg ? (32'd0 - inB) : inB;
  assign div_zero = (inB == 32'd0);
  assign divisor  = div_zero ? 32'd1 : b_mag;
  assign q_mag    = a_mag / divisor;
  assign r_mag    = a_mag % divisor;
  assign q_res    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign r_res    = a_neg ? (32'd0 - r_mag) : r_mag;

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    res_wr = 1'b0;
    case (MDUop)
      OP_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
        res_wr = 1'b1;
      end
      OP_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
        res_wr = 1'b1;
      end
      OP_DIV, OP_DIVU: begin
        res_hi = r_res;
        res_lo = q_res;
        res_wr = !div_zero;
      end
      default: begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        res_wr = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_wr <= 1'b0;
      HI      <= 32'd0;
      LO      <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            pend_hi <= res_hi;
            pend_lo <= res_lo;
            pend_wr <= res_wr;
            cnt     <= is_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            state   <= ST_BUSY;
          end
          if (!req && (MDUop == OP_MTHI)) HI <= inA;
          if (!req && (MDUop == OP_MTLO)) LO <= inA;
        end
        ST_BUSY: begin
          if (cnt == CNT_W'(1)) begin
            state <= ST_IDLE;
            cnt   <= '0;
            if (pend_wr) begin
              HI <= pend_hi;
              LO <= pend_lo;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    MDUout = 32'd0;
    case (MDUop)
      OP_MFHI: MDUout = HI;
      OP_MFLO: MDUout = LO;
      default: MDUout = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_mdu_e.sv
// Scoreboard bench for mdu_e: stimulus pushes expected HI/LO and busy length,
// a monitor pops and compares on every busy falling edge.
module tb_mdu_e;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  MDUop;
  logic        start;
  logic [31:0] inA;
  logic [31:0] inB;
  logic        req;
  logic        busy;
  logic [31:0] MDUout;
  logic [31:0] HI;
  logic [31:0] LO;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  mdu_e #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .MDUop(MDUop), .start(start),
    .inA(inA), .inB(inB), .req(req), .busy(busy),
    .MDUout(MDUout), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: completion is any busy fall not caused by reset.
  logic rst_q = 1'b0;
  logic busy_prev = 1'b0;
  int   bcnt = 0;
  always @(posedge clk) rst_q <= reset;

  always @(negedge clk) begin
    exp_t e;
    if (busy === 1'b1) begin
      bcnt = bcnt + 1;
    end else begin
      if (busy_prev === 1'b1 && rst_q === 1'b0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_completion", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("done_hi", HI, e.hi);
          chk("done_lo", LO, e.lo);
          chk("busy_cycles", 32'(bcnt), 32'(e.cycles));
        end
      end
      bcnt = 0;
    end
    busy_prev = busy;
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic st, input logic rq);
    MDUop = op; inA = a; inB = b; start = st; req = rq;
    @(posedge clk); #1;
    MDUop = OP_NONE; start = 1'b0; req = 1'b0;
  endtask

  task automatic push_exp(input logic [31:0] h, input logic [31:0] l, input int n);
    exp_t e;
    e.hi = h; e.lo = l; e.cycles = n;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy !== 1'b0) chk("wait_idle_timeout", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset = 1'b1; MDUop = OP_NONE; start = 1'b0; inA = 32'd0; inB = 32'd0; req = 1'b0;
    idle(2);
    reset = 1'b0;
    idle(1);
    chk("reset_hi", HI, 32'd0);
    chk("reset_lo", LO, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    MDUop = OP_MFHI; #1;
    chk("reset_mfhi", MDUout, 32'd0);
    MDUop = OP_NONE;

    // reset mid-div: dropped without writing HI/LO
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b1, 1'b0);
    chk("div_busy_rise", {31'd0, busy}, 32'd1);
    idle(3);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    chk("midreset_hi", HI, 32'd0);
    chk("midreset_lo", LO, 32'd0);
    idle(12);
    chk("midreset_lo_later", LO, 32'd0);

    push_exp(32'hFFFFFFFF, 32'hFFFFFFFA, 5);
    issue(OP_MULT, 32'hFFFFFFFE, 32'd3, 1'b1, 1'b0);
    wait_idle();

    push_exp(32'h00000002, 32'hFFFFFFFA, 5);
    issue(OP_MULTU, 32'hFFFFFFFE, 32'd3, 1'b1, 1'b0);
    wait_idle();

    push_exp(32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b1, 1'b0);
    wait_idle();

    push_exp(32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    issue(OP_DIVU, 32'd7, 32'd0, 1'b1, 1'b0);
    wait_idle();

    push_exp(32'h00000000, 32'h80000000, 10);
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0);
    wait_idle();

    issue(OP_MTLO, 32'h12345678, 32'd0, 1'b0, 1'b0);
    MDUop = OP_MFLO; #1;
    chk("mflo_after_mtlo", MDUout, 32'h12345678);
    MDUop = OP_MFHI; #1;
    chk("mfhi_after_mtlo", MDUout, 32'h00000000);
    MDUop = OP_NONE;

    issue(OP_MTHI, 32'hDEADBEEF, 32'd0, 1'b0, 1'b1);
    chk("mthi_req_hi", HI, 32'h00000000);

    issue(OP_MULT, 32'd9, 32'd9, 1'b1, 1'b1);
    chk("mult_req_busy", {31'd0, busy}, 32'd0);
    idle(6);
    chk("mult_req_hi", HI, 32'h00000000);
    chk("mult_req_lo", LO, 32'h12345678);

    // second start while busy must be ignored
    push_exp(32'h00000000, 32'h00000200, 5);
    issue(OP_MULT, 32'h10, 32'h20, 1'b1, 1'b0);
    idle(1);
    issue(OP_MULTU, 32'd5, 32'd7, 1'b1, 1'b0);
    wait_idle();

    // req during an in-flight op does not cancel it
    push_exp(32'd2, 32'd14, 10);
    issue(OP_DIVU, 32'd100, 32'd7, 1'b1, 1'b0);
    idle(1);
    req = 1'b1;
    idle(4);
    req = 1'b0;
    wait_idle();

    MDUop = OP_NONE; #1;
    chk("mduout_none", MDUout, 32'd0);
    MDUop = OP_MFHI; #1;
    chk("mfhi_final", MDUout, 32'd2);
    MDUop = OP_NONE;

    idle(3);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
